// File: rtl/sysbus_arbiter_pkg.sv
// Shared types for the system bus arbiter.
// FSM state encoding, round-robin pointer and tie-break helper.
package sysbus_arbiter_pkg;

  typedef enum logic [1:0] {
    SB_IDLE,
    SB_GNT_I,
    SB_GNT_D
  } SbArbState;

  // Which L1 completed the most recent transaction.
  typedef enum logic {
    SB_RR_I = 1'b0,
    SB_RR_D = 1'b1
  } SbRrPtr;

  // Grant choice from IDLE; a tie goes to the L1 not served last.
  function automatic SbArbState sb_pick(
    input logic   i_req,
    input logic   d_req,
    input SbRrPtr last
  );
    SbArbState s;
    s = SB_IDLE;
    if (i_req && d_req) begin
      s = (last == SB_RR_D) ? SB_GNT_I : SB_GNT_D;
    end else if (i_req) begin
      s = SB_GNT_I;
    end else if (d_req) begin
      s = SB_GNT_D;
    end
    return s;
  endfunction

endpackage

// File: rtl/sysbus_inv_bcast.sv
// Invalidation broadcast to both L1 caches.
// Upstream ack waits until each L1 has taken the request exactly once.
module sysbus_inv_bcast #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m_inv_valid,
  input  logic [ADDR_WIDTH-1:0] m_inv_addr,
  output logic                  m_inv_ready,
  output logic                  i_inv_valid,
  output logic [ADDR_WIDTH-1:0] i_inv_addr,
  input  logic                  i_inv_ready,
  output logic                  d_inv_valid,
  output logic [ADDR_WIDTH-1:0] d_inv_addr,
  input  logic                  d_inv_ready
);

  logic ack_i_q, ack_i_d;
  logic ack_d_q, ack_d_d;

  // Fan out the request; an L1 that already accepted sees valid low.
  always_comb begin
    i_inv_addr  = m_inv_addr;
    d_inv_addr  = m_inv_addr;
    i_inv_valid = m_inv_valid && !ack_i_q;
    d_inv_valid = m_inv_valid && !ack_d_q;
    m_inv_ready = m_inv_valid
                && (ack_i_q || i_inv_ready)
                && (ack_d_q || d_inv_ready);
  end

  // Sticky per-L1 acks, dropped once upstream handshake completes.
  always_comb begin
    ack_i_d = ack_i_q || (i_inv_valid && i_inv_ready);
    ack_d_d = ack_d_q || (d_inv_valid && d_inv_ready);
    if (m_inv_ready) begin
      ack_i_d = 1'b0;
      ack_d_d = 1'b0;
    end
  end

  // Ack flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_i_q <= 1'b0;
      ack_d_q <= 1'b0;
    end else begin
      ack_i_q <= ack_i_d;
      ack_d_q <= ack_d_d;
    end
  end

endmodule

// File: rtl/sysbus_arbiter.sv
// Two-master arbiter: L1i and L1d onto the system cache port.
// Round-robin grant held for a whole ReadWrite transaction.
module sysbus_arbiter
  import sysbus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  // L1i ReadWrite
  input  logic                  i_rw_valid,
  input  logic [ADDR_WIDTH-1:0] i_rw_addr,
  input  logic                  i_rw_we,
  input  logic                  i_w_ce,
  input  logic [MASK_WIDTH-1:0] i_w_mask,
  input  logic [DATA_WIDTH-1:0] i_w_data,
  output logic                  i_rw_ready,
  output logic [DATA_WIDTH-1:0] i_r_data,
  // L1d ReadWrite
  input  logic                  d_rw_valid,
  input  logic [ADDR_WIDTH-1:0] d_rw_addr,
  input  logic                  d_rw_we,
  input  logic                  d_w_ce,
  input  logic [MASK_WIDTH-1:0] d_w_mask,
  input  logic [DATA_WIDTH-1:0] d_w_data,
  output logic                  d_rw_ready,
  output logic [DATA_WIDTH-1:0] d_r_data,
  // System cache ReadWrite
  output logic                  m_rw_valid,
  output logic [ADDR_WIDTH-1:0] m_rw_addr,
  output logic                  m_rw_we,
  output logic                  m_w_ce,
  output logic [MASK_WIDTH-1:0] m_w_mask,
  output logic [DATA_WIDTH-1:0] m_w_data,
  input  logic                  m_rw_ready,
  input  logic [DATA_WIDTH-1:0] m_r_data,
  // Invalidation
  input  logic                  m_inv_valid,
  input  logic [ADDR_WIDTH-1:0] m_inv_addr,
  output logic                  m_inv_ready,
  output logic                  i_inv_valid,
  output logic [ADDR_WIDTH-1:0] i_inv_addr,
  input  logic                  i_inv_ready,
  output logic                  d_inv_valid,
  output logic [ADDR_WIDTH-1:0] d_inv_addr,
  input  logic                  d_inv_ready
);

  SbArbState state_q, state_d;
  SbRrPtr    rr_q, rr_d;

  // Read data is shared; each L1 qualifies it with its own ready.
  always_comb begin
    i_r_data = m_r_data;
    d_r_data = m_r_data;
  end

  // Grant FSM next state, payload mux and ready steering.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    m_rw_valid = 1'b0;
    m_rw_addr  = '0;
    m_rw_we    = 1'b0;
    m_w_ce     = 1'b0;
    m_w_mask   = '0;
    m_w_data   = '0;
    i_rw_ready = 1'b0;
    d_rw_ready = 1'b0;
    case (state_q)
      SB_IDLE: begin
        state_d = sb_pick(i_rw_valid, d_rw_valid, rr_q);
      end
      SB_GNT_I: begin
        m_rw_valid = i_rw_valid;
        m_rw_addr  = i_rw_addr;
        m_rw_we    = i_rw_we;
        m_w_ce     = i_w_ce;
        m_w_mask   = i_w_mask;
        m_w_data   = i_w_data;
        i_rw_ready = m_rw_ready;
        if (m_rw_valid && m_rw_ready) begin
          state_d = SB_IDLE;
          rr_d    = SB_RR_I;
        end
      end
      SB_GNT_D: begin
        m_rw_valid = d_rw_valid;
        m_rw_addr  = d_rw_addr;
        m_rw_we    = d_rw_we;
        m_w_ce     = d_w_ce;
        m_w_mask   = d_w_mask;
        m_w_data   = d_w_data;
        d_rw_ready = m_rw_ready;
        if (m_rw_valid && m_rw_ready) begin
          state_d = SB_IDLE;
          rr_d    = SB_RR_D;
        end
      end
      default: begin
        state_d = SB_IDLE;
      end
    endcase
  end

  // State and round-robin registers; D as last-served lets L1i win first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SB_IDLE;
      rr_q    <= SB_RR_D;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
    end
  end

  sysbus_inv_bcast #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_inv (
    .clk         (clk),
    .rst         (rst),
    .m_inv_valid (m_inv_valid),
    .m_inv_addr  (m_inv_addr),
    .m_inv_ready (m_inv_ready),
    .i_inv_valid (i_inv_valid),
    .i_inv_addr  (i_inv_addr),
    .i_inv_ready (i_inv_ready),
    .d_inv_valid (d_inv_valid),
    .d_inv_addr  (d_inv_addr),
    .d_inv_ready (d_inv_ready)
  );

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Self-checking bench for sysbus_arbiter.
// Scoreboard queues filled by stimulus, drained by a negedge monitor.
module tb_sysbus_arbiter;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int MW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_rw_valid, d_rw_valid;
  logic [AW-1:0] i_rw_addr, d_rw_addr;
  logic          i_rw_we, d_rw_we, i_w_ce, d_w_ce;
  logic [MW-1:0] i_w_mask, d_w_mask;
  logic [DW-1:0] i_w_data, d_w_data;
  logic          i_rw_ready, d_rw_ready;
  logic [DW-1:0] i_r_data, d_r_data;
  logic          m_rw_valid, m_rw_we, m_w_ce;
  logic [AW-1:0] m_rw_addr;
  logic [MW-1:0] m_w_mask;
  logic [DW-1:0] m_w_data;
  logic          m_rw_ready;
  logic [DW-1:0] m_r_data;
  logic          m_inv_valid, m_inv_ready;
  logic [AW-1:0] m_inv_addr, i_inv_addr, d_inv_addr;
  logic          i_inv_valid, d_inv_valid;
  logic          i_inv_ready, d_inv_ready;

  always #5 clk = ~clk;

  sysbus_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MASK_WIDTH (MW)
  ) dut (
    .clk (clk), .rst (rst),
    .i_rw_valid (i_rw_valid), .i_rw_addr (i_rw_addr),
    .i_rw_we (i_rw_we), .i_w_ce (i_w_ce),
    .i_w_mask (i_w_mask), .i_w_data (i_w_data),
    .i_rw_ready (i_rw_ready), .i_r_data (i_r_data),
    .d_rw_valid (d_rw_valid), .d_rw_addr (d_rw_addr),
    .d_rw_we (d_rw_we), .d_w_ce (d_w_ce),
    .d_w_mask (d_w_mask), .d_w_data (d_w_data),
    .d_rw_ready (d_rw_ready), .d_r_data (d_r_data),
    .m_rw_valid (m_rw_valid), .m_rw_addr (m_rw_addr),
    .m_rw_we (m_rw_we), .m_w_ce (m_w_ce),
    .m_w_mask (m_w_mask), .m_w_data (m_w_data),
    .m_rw_ready (m_rw_ready), .m_r_data (m_r_data),
    .m_inv_valid (m_inv_valid), .m_inv_addr (m_inv_addr),
    .m_inv_ready (m_inv_ready),
    .i_inv_valid (i_inv_valid), .i_inv_addr (i_inv_addr),
    .i_inv_ready (i_inv_ready),
    .d_inv_valid (d_inv_valid), .d_inv_addr (d_inv_addr),
    .d_inv_ready (d_inv_ready)
  );

  typedef struct {
    logic          is_d;
    logic [AW-1:0] addr;
    logic          we;
    logic          ce;
    logic [MW-1:0] mask;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } rw_exp_t;

  rw_exp_t       rwq[$];
  logic [AW-1:0] invq[$];
  int            total = 0;
  int            bad = 0;

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", n, a, e);
    end
  endtask

  task automatic fail(input string n);
    total++;
    bad++;
    $display("FAIL %s act=event exp=none", n);
  endtask

  task automatic push_rw(input logic is_d, input logic [AW-1:0] a,
                         input logic we, input logic ce,
                         input logic [MW-1:0] mk,
                         input logic [DW-1:0] wd,
                         input logic [DW-1:0] rd);
    rw_exp_t e;
    e.is_d = is_d; e.addr = a; e.we = we; e.ce = ce;
    e.mask = mk; e.wdata = wd; e.rdata = rd;
    rwq.push_back(e);
  endtask

  // ReadWrite and invalidation monitor.
  rw_exp_t ex;
  int      cnt_i = 0;
  int      cnt_d = 0;
  logic [AW-1:0] ia;
  always @(negedge clk) begin
    if (rst) begin
      cnt_i = 0;
      cnt_d = 0;
    end else begin
      chk("both_ready", {63'd0, i_rw_ready & d_rw_ready}, 64'd0);
      if (m_rw_valid && m_rw_ready) begin
        if (rwq.size() == 0) fail("rw_unexpected");
        else begin
          ex = rwq.pop_front();
          chk("rw_who_d", {63'd0, d_rw_ready}, {63'd0, ex.is_d});
          chk("rw_who_i", {63'd0, i_rw_ready}, {63'd0, !ex.is_d});
          chk("rw_addr", m_rw_addr, ex.addr);
          chk("rw_we", {63'd0, m_rw_we}, {63'd0, ex.we});
          chk("rw_ce", {63'd0, m_w_ce}, {63'd0, ex.ce});
          chk("rw_mask", m_w_mask, ex.mask);
          chk("rw_wdata", m_w_data, ex.wdata);
          chk("rw_rdata", ex.is_d ? d_r_data : i_r_data, ex.rdata);
        end
      end
      if (i_inv_valid && i_inv_ready) cnt_i++;
      if (d_inv_valid && d_inv_ready) cnt_d++;
      if (m_inv_valid && m_inv_ready) begin
        if (invq.size() == 0) fail("inv_unexpected");
        else begin
          ia = invq.pop_front();
          chk("inv_addr_i", i_inv_addr, ia);
          chk("inv_addr_d", d_inv_addr, ia);
          chk("inv_hs_i", cnt_i, 1);
          chk("inv_hs_d", cnt_d, 1);
        end
        cnt_i = 0;
        cnt_d = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    i_rw_valid = 0; i_rw_addr = '0; i_rw_we = 0; i_w_ce = 0;
    i_w_mask = '0; i_w_data = '0;
    d_rw_valid = 0; d_rw_addr = '0; d_rw_we = 0; d_w_ce = 0;
    d_w_mask = '0; d_w_data = '0;
    m_rw_ready = 0; m_r_data = '0;
    m_inv_valid = 0; m_inv_addr = '0;
    i_inv_ready = 0; d_inv_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask

  int gexp[6];
  int g;
  int pulses;

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    clear_in();
    rst = 1;
    tick();
    tick();
    @(negedge clk);
    chk("rst_m_valid", {63'd0, m_rw_valid}, 0);
    chk("rst_i_ready", {63'd0, i_rw_ready}, 0);
    chk("rst_d_ready", {63'd0, d_rw_ready}, 0);
    chk("rst_m_addr", m_rw_addr, 0);
    chk("rst_inv_rdy", {63'd0, m_inv_ready}, 0);

    // Single L1d read
    tick();
    rst = 0;
    d_rw_valid = 1; d_rw_addr = 32'h1000;
    @(negedge clk);
    chk("t1_idle_valid", {63'd0, m_rw_valid}, 0);
    tick();
    m_rw_ready = 1; m_r_data = 64'hDEADBEEF_CAFEF00D;
    push_rw(1, 32'h1000, 0, 0, 0, 0, 64'hDEADBEEF_CAFEF00D);
    @(negedge clk);
    chk("t1_m_valid", {63'd0, m_rw_valid}, 1);
    chk("t1_m_addr", m_rw_addr, 32'h1000);
    chk("t1_d_ready", {63'd0, d_rw_ready}, 1);
    chk("t1_d_data", d_r_data, 64'hDEADBEEF_CAFEF00D);
    chk("t1_i_ready", {63'd0, i_rw_ready}, 0);
    tick();
    clear_in();

    // Both request, cache always ready: I, -, D, -, I
    do_reset();
    i_rw_valid = 1; i_rw_addr = 32'h100;
    d_rw_valid = 1; d_rw_addr = 32'h200;
    m_rw_ready = 1; m_r_data = 64'h01234567_89ABCDEF;
    push_rw(0, 32'h100, 0, 0, 0, 0, 64'h01234567_89ABCDEF);
    push_rw(1, 32'h200, 0, 0, 0, 0, 64'h01234567_89ABCDEF);
    push_rw(0, 32'h100, 0, 0, 0, 0, 64'h01234567_89ABCDEF);
    gexp = '{0, 1, 0, 2, 0, 1};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      g = !m_rw_valid ? 0 : (m_rw_addr == 32'h100 ? 1 : 2);
      chk($sformatf("t2_grant_c%0d", c), g, gexp[c]);
      tick();
    end
    clear_in();

    // L1d write, cache ready after 3 wait cycles
    d_rw_valid = 1; d_rw_addr = 32'h3000; d_rw_we = 1;
    d_w_ce = 1; d_w_mask = 8'h0F;
    d_w_data = 64'h11223344_55667788;
    m_r_data = 64'h0;
    pulses = 0;
    @(negedge clk);
    pulses += int'(d_rw_ready);
    tick();
    for (int c = 1; c < 5; c++) begin
      if (c == 4) begin
        m_rw_ready = 1;
        push_rw(1, 32'h3000, 1, 1, 8'h0F,
                64'h11223344_55667788, 64'h0);
      end
      @(negedge clk);
      chk($sformatf("t3_valid_c%0d", c), {63'd0, m_rw_valid}, 1);
      chk($sformatf("t3_mask_c%0d", c), m_w_mask, 8'h0F);
      chk($sformatf("t3_data_c%0d", c), m_w_data,
          64'h11223344_55667788);
      chk($sformatf("t3_ce_c%0d", c), {63'd0, m_w_ce}, 1);
      pulses += int'(d_rw_ready);
      tick();
    end
    clear_in();
    @(negedge clk);
    pulses += int'(d_rw_ready);
    chk("t3_pulses", pulses, 1);

    // Invalidation, L1d late
    tick();
    m_inv_valid = 1; m_inv_addr = 32'h2040;
    i_inv_ready = 1; d_inv_ready = 0;
    invq.push_back(32'h2040);
    @(negedge clk);
    chk("t4_c0_iv", {63'd0, i_inv_valid}, 1);
    chk("t4_c0_dv", {63'd0, d_inv_valid}, 1);
    chk("t4_c0_mr", {63'd0, m_inv_ready}, 0);
    tick();
    @(negedge clk);
    chk("t4_c1_iv", {63'd0, i_inv_valid}, 0);
    chk("t4_c1_dv", {63'd0, d_inv_valid}, 1);
    chk("t4_c1_mr", {63'd0, m_inv_ready}, 0);
    tick();
    d_inv_ready = 1;
    @(negedge clk);
    chk("t4_c2_dv", {63'd0, d_inv_valid}, 1);
    chk("t4_c2_mr", {63'd0, m_inv_ready}, 1);
    tick();
    m_inv_addr = 32'h2080; i_inv_ready = 0; d_inv_ready = 0;
    invq.push_back(32'h2080);
    @(negedge clk);
    chk("t4_c3_iv", {63'd0, i_inv_valid}, 1);
    chk("t4_c3_dv", {63'd0, d_inv_valid}, 1);
    chk("t4_c3_mr", {63'd0, m_inv_ready}, 0);
    tick();
    i_inv_ready = 1; d_inv_ready = 1;
    @(negedge clk);
    chk("t4_c4_mr", {63'd0, m_inv_ready}, 1);
    tick();
    clear_in();

    // Reset while L1d granted and waiting
    d_rw_valid = 1; d_rw_addr = 32'h4000;
    tick();
    @(negedge clk);
    chk("t5_gnt_d", m_rw_addr, 32'h4000);
    tick();
    i_rw_valid = 1; i_rw_addr = 32'h5000;
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    chk("t5_after_rst", {63'd0, m_rw_valid}, 0);
    tick();
    m_rw_ready = 1; m_r_data = 64'hA5A5_0000_5A5A_FFFF;
    push_rw(0, 32'h5000, 0, 0, 0, 0, 64'hA5A5_0000_5A5A_FFFF);
    push_rw(1, 32'h4000, 0, 0, 0, 0, 64'hA5A5_0000_5A5A_FFFF);
    @(negedge clk);
    chk("t5_first_i", m_rw_addr, 32'h5000);
    chk("t5_i_ready", {63'd0, i_rw_ready}, 1);
    tick();
    i_rw_valid = 0;
    tick();
    @(negedge clk);
    chk("t5_then_d", m_rw_addr, 32'h4000);
    tick();
    clear_in();

    // Concurrent invalidation and ReadWrite
    d_rw_valid = 1; d_rw_addr = 32'h6000;
    m_rw_ready = 1; m_r_data = 64'h0F0F_1234_5678_F0F0;
    push_rw(1, 32'h6000, 0, 0, 0, 0, 64'h0F0F_1234_5678_F0F0);
    m_inv_valid = 1; m_inv_addr = 32'h7000;
    i_inv_ready = 1; d_inv_ready = 1;
    invq.push_back(32'h7000);
    @(negedge clk);
    chk("t6_c0_mr", {63'd0, m_inv_ready}, 1);
    chk("t6_c0_mv", {63'd0, m_rw_valid}, 0);
    chk("t6_c0_dr", {63'd0, d_rw_ready}, 0);
    tick();
    m_inv_addr = 32'h7040; d_inv_ready = 0;
    invq.push_back(32'h7040);
    @(negedge clk);
    chk("t6_c1_mv", {63'd0, m_rw_valid}, 1);
    chk("t6_c1_dr", {63'd0, d_rw_ready}, 1);
    chk("t6_c1_mr", {63'd0, m_inv_ready}, 0);
    tick();
    d_rw_valid = 0; d_inv_ready = 1;
    @(negedge clk);
    chk("t6_c2_mr", {63'd0, m_inv_ready}, 1);
    chk("t6_c2_mv", {63'd0, m_rw_valid}, 0);
    tick();
    clear_in();

    tick();
    tick();
    chk("rwq_empty", rwq.size(), 0);
    chk("invq_empty", invq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sysbus_arbiter.md
# sysbus_arbiter

Two-master arbiter placing the L1 instruction cache and L1 data cache on the single system bus provider (system cache). It serialises the ReadWrite channel with a round-robin grant held for a whole transaction, and broadcasts each Invalidation request to both L1s, acknowledging upstream only after both have accepted it. It sits between the L1i/L1d bus user ports and the system cache provider port.

## Interface

Parameters:
- ADDR_WIDTH, 32, bus address width
- DATA_WIDTH, 64, bus data width
- MASK_WIDTH, DATA_WIDTH/8, write byte-mask width

Ports (signals of an x-side ReadWrite channel use prefix x_: i_ = L1i, d_ = L1d, m_ = system cache):
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset; synchronous, active-high
- i_rw_valid, d_rw_valid  in  1  request from each L1
- i_rw_addr, d_rw_addr  in  ADDR_WIDTH  request address
- i_rw_we, d_rw_we  in  1  write enable
- i_w_ce, d_w_ce  in  1  write chip-enable
- i_w_mask, d_w_mask  in  MASK_WIDTH  write byte mask
- i_w_data, d_w_data  in  DATA_WIDTH  write data
- i_rw_ready, d_rw_ready  out  1  completion to each L1
- i_r_data, d_r_data  out  DATA_WIDTH  read data to each L1
- m_rw_valid  out  1  request to system cache
- m_rw_addr  out  ADDR_WIDTH; m_rw_we, m_w_ce  out  1; m_w_mask  out  MASK_WIDTH; m_w_data  out  DATA_WIDTH
- m_rw_ready  in  1  completion from system cache
- m_r_data  in  DATA_WIDTH  read data
- m_inv_valid  in  1; m_inv_addr  in  ADDR_WIDTH  invalidation from system cache
- m_inv_ready  out  1  invalidation accepted by both L1s
- i_inv_valid, d_inv_valid  out  1; i_inv_addr, d_inv_addr  out  ADDR_WIDTH
- i_inv_ready, d_inv_ready  in  1

## Operation

- Handshake: a transaction completes in the cycle with valid && ready. Requester holds valid and all payload stable until completion. System cache may hold m_rw_ready high arbitrarily; it counts only while m_rw_valid is high.
- FSM states: IDLE, GNT_I, GNT_D.
  - IDLE: if only one L1 requests, go to that grant. If both request, grant the one not served last (rr pointer). If neither requests, stay.
  - GNT_x: m_rw_* = x's payload; m_rw_valid = x_rw_valid. x_rw_ready = m_rw_ready; the other L1's ready = 0. On m_rw_valid && m_rw_ready: go to IDLE and set rr pointer to x.
  - Requester dropping valid while granted is illegal; the bus does not check it.
- IDLE: m_rw_valid = 0 and both x_rw_ready = 0. Payload outputs are don't-care; drive zero.
- i_r_data = d_r_data = m_r_data unconditionally. Data is meaningful only with the matching ready.
- Invalidation broadcast:
  - i_inv_addr = d_inv_addr = m_inv_addr.
  - Per-L1 sticky ack flags ack_i and ack_d.
  - x_inv_valid = m_inv_valid && !ack_x. Set ack_x on x_inv_valid && x_inv_ready.
  - m_inv_ready = m_inv_valid && (ack_i || i_inv_ready) && (ack_d || d_inv_ready).
  - On upstream handshake, clear both flags. Each L1 therefore sees exactly one handshake per invalidation.
  - Invalidation runs independently of the ReadWrite FSM; both channels may be active in the same cycle.

## Timing

- Reset values: state = IDLE, rr pointer = D (L1i wins the first tie), ack_i = ack_d = 0. All outputs 0 during and after reset until a request arrives.
- Arbitration latency: x_rw_valid rising in cycle N gives m_rw_valid high in cycle N+1, if IDLE in cycle N.
- Completion cycle C: m_rw_ready and x_rw_ready coincide (combinational pass-through). State is IDLE in C+1. The next grant's m_rw_valid is at C+2 at earliest. There is one bubble per transaction.
- Back-to-back requests from both L1s strictly alternate: I, D, I, D…
- A single L1 requesting continuously is granted every other cycle minimum.
- Invalidation: m_inv_ready can assert in the same cycle as m_inv_valid, if both L1s are ready. Otherwise it asserts in the cycle the last L1 accepts.
- Reset mid-transaction: the next cycle is IDLE with m_rw_valid = 0. An in-flight request is abandoned; the system cache is reset by the same rst. Ack flags clear.

## Structure

- Add typedef enum logic [1:0] {SB_IDLE, SB_GNT_I, SB_GNT_D} SbArbState to the shared common header, beside PipeRequest/PipeControl.
- Sub-module sysbus_inv_bcast holds the two ack flags and the invalidation logic, parameterised by ADDR_WIDTH. It is instantiated once.
- The top level contains the FSM, the rr pointer and the payload muxes.

## Test plan

- Reset, then d_rw_valid=1, addr=0x1000, we=0. Required: m_rw_valid=1, m_rw_addr=0x1000 the next cycle. Then m_rw_ready=1, m_r_data=0xDEADBEEF_CAFEF00D gives d_rw_ready=1, d_r_data=0xDEADBEEF_CAFEF00D, and i_rw_ready=0.
- Reset, then i_rw_valid and d_rw_valid both asserted at cycle 0, cache ready every cycle. Required grants: I at cycle 1, D at cycle 3, I at cycle 5. No cycle has both readies high.
- Write via L1d with mask=0x0F, data=0x11223344_55667788, cache ready delayed 3 cycles. Required: m_w_mask, m_w_data and m_w_ce held stable for all 4 valid cycles, and exactly one d_rw_ready pulse.
- m_inv_valid=1, addr=0x2040, i_inv_ready=1 at cycle 0, d_inv_ready=1 only at cycle 2. Required: i_inv_valid drops at cycle 1, d_inv_valid stays high through cycle 2, m_inv_ready=1 only at cycle 2, flags clear at cycle 3.
- Assert rst while GNT_D with m_rw_ready=0. Required: m_rw_valid=0 the next cycle, and the first grant after reset is I when both request.
- Concurrent invalidation and ReadWrite traffic. Required: neither channel's handshake timing changes relative to running it alone.
